// File: rtl/div_sequencer.sv
// div_sequencer: execute-stage sequencer for the iterative divider.
// Accepts SDIV/UDIV requests and resolves x/0 and MIN/-1 locally.
// Otherwise it launches the divider, waits for done or a hang limit, and
// returns the quotient with its rd tag. The core stays stalled meanwhile.
// Ports:
//   clk, reset (async, active-low)
//   req_*     : request from the core (held while stall=1)
//   flush     : squash the in-flight operation
//   div_*     : launch/abort/operands to the divider, quotient/done back
//   stall     : combinational core stall
//   res_*     : one-cycle result strobe, value and tag to writeback
//   timeout   : sticky flag, set when a divide hit the wait limit
`timescale 1ns/1ps

module div_sequencer #(
    parameter int SIZE     = 64,
    parameter int MAX_WAIT = 80
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_signed,
    input  logic [SIZE-1:0] req_dividend,
    input  logic [SIZE-1:0] req_divisor,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            div_start,
    output logic            div_abort,
    output logic            div_signed,
    output logic [SIZE-1:0] div_dividend,
    output logic [SIZE-1:0] div_divisor,
    input  logic [SIZE-1:0] div_quotient,
    input  logic            div_done,
    output logic            stall,
    output logic            res_valid,
    output logic [SIZE-1:0] res_value,
    output logic [4:0]      res_rd,
    output logic            timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);
    localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESULT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    rd_q;
    logic          div_zero;
    logic          sgn_ovf;

    assign div_zero = (req_divisor == '0);
    // MIN / -1 overflows; the architectural result is the dividend itself.
    assign sgn_ovf  = req_signed
                   && (req_dividend == MIN_NEG)
                   && (req_divisor == '1);

    // Released during RESULT so the core retires the request that cycle.
    assign stall = req_valid && (state != RESULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            rd_q         <= '0;
            div_start    <= 1'b0;
            div_abort    <= 1'b0;
            div_signed   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            res_valid    <= 1'b0;
            res_value    <= '0;
            res_rd       <= '0;
            timeout      <= 1'b0;
        end else begin
            div_start <= 1'b0;
            div_abort <= 1'b0;
            res_valid <= 1'b0;
            if (flush) begin
                // Only a launched divide needs the divider reset.
                if (state == LAUNCH || state == WAIT) begin
                    div_abort <= 1'b1;
                end
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req_valid) begin
                            div_signed   <= req_signed;
                            div_dividend <= req_dividend;
                            div_divisor  <= req_divisor;
                            rd_q         <= req_rd;
                            if (div_zero) begin
                                res_value <= '0;
                                res_rd    <= req_rd;
                                res_valid <= 1'b1;
                                state     <= RESULT;
                            end else if (sgn_ovf) begin
                                res_value <= req_dividend;
                                res_rd    <= req_rd;
                                res_valid <= 1'b1;
                                state     <= RESULT;
                            end else begin
                                div_start <= 1'b1;
                                state     <= LAUNCH;
                            end
                        end
                    end
                    LAUNCH: begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // done is checked first so it wins on the limit cycle
                        if (div_done) begin
                            res_value <= div_quotient;
                            res_rd    <= rd_q;
                            res_valid <= 1'b1;
                            state     <= RESULT;
                        end else if (wait_cnt == LIMIT) begin
                            res_value <= '0;
                            res_rd    <= rd_q;
                            res_valid <= 1'b1;
                            timeout   <= 1'b1;
                            div_abort <= 1'b1;
                            state     <= RESULT;
                        end
                    end
                    RESULT: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed + random checks of div_sequencer (SIZE=16)
// against a plain-arithmetic quotient model and a delay-driven divider model.
`timescale 1ns/1ps

module tb_div_sequencer;

    localparam int SZ = 16;
    localparam int MW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_signed = 1'b0;
    logic [SZ-1:0] req_dividend = '0;
    logic [SZ-1:0] req_divisor = '0;
    logic [4:0]    req_rd = '0;
    logic          flush = 1'b0;
    logic          div_start;
    logic          div_abort;
    logic          div_signed;
    logic [SZ-1:0] div_dividend;
    logic [SZ-1:0] div_divisor;
    logic [SZ-1:0] div_quotient;
    logic          div_done;
    logic          stall;
    logic          res_valid;
    logic [SZ-1:0] res_value;
    logic [4:0]    res_rd;
    logic          timeout;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int rv_cnt = 0;
    int mdl_delay = 0;
    int mdl_cnt;
    logic mdl_busy;
    bit tmo_seen = 0;

    div_sequencer #(.SIZE(SZ), .MAX_WAIT(MW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_signed   (req_signed),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_rd       (req_rd),
        .flush        (flush),
        .div_start    (div_start),
        .div_abort    (div_abort),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_done     (div_done),
        .stall        (stall),
        .res_valid    (res_valid),
        .res_value    (res_value),
        .res_rd       (res_rd),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Architectural quotient: truncating division, x/0 gives 0.
    function automatic logic [SZ-1:0] qref(input logic s,
                                           input logic [SZ-1:0] a,
                                           input logic [SZ-1:0] b);
        int x;
        int y;
        if (b == '0) return '0;
        if (s) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return SZ'(x / y);
    endfunction

    // Divider model: done appears mdl_delay WAIT cycles after the launch.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_busy     <= 1'b0;
            mdl_cnt      <= 0;
            div_done     <= 1'b0;
            div_quotient <= '0;
        end else if (div_start) begin
            mdl_busy     <= 1'b1;
            mdl_cnt      <= 0;
            div_done     <= (mdl_delay == 0);
            div_quotient <= qref(div_signed, div_dividend, div_divisor);
        end else if (div_abort || div_done) begin
            mdl_busy <= 1'b0;
            div_done <= 1'b0;
        end else if (mdl_busy) begin
            mdl_cnt  <= mdl_cnt + 1;
            div_done <= (mdl_cnt + 1 == mdl_delay);
        end
    end

    always @(posedge clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
        if (div_abort) abort_cnt <= abort_cnt + 1;
        if (res_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [SZ-1:0] a,
                         input logic [SZ-1:0] b, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_signed   = s;
        req_dividend = a;
        req_divisor  = b;
        req_rd       = rd;
    endtask

    // Called in an IDLE cycle; accepted at the next edge (cycle 0).
    // Returns in the IDLE cycle after RESULT with req_valid low.
    task automatic run_op(input logic s, input logic [SZ-1:0] a,
                          input logic [SZ-1:0] b, input logic [4:0] rd,
                          input int dly);
        bit special;
        bit tmo;
        int ecyc;
        int cyc;
        int s0;
        logic [SZ-1:0] eq;
        special = (b == '0) || (s && a == 16'h8000 && b == 16'hFFFF);
        tmo     = !special && dly >= MW;
        eq      = tmo ? '0 : qref(s, a, b);
        ecyc    = special ? 1 : (tmo ? MW + 2 : dly + 3);
        mdl_delay = dly;
        drive(s, a, b, rd);
        #1;
        chk("stall_idle", stall, 1);
        s0 = start_cnt;
        step();
        cyc = 1;
        while (res_valid !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        tmo_seen = tmo_seen || tmo;
        chk("res_valid", res_valid, 1);
        chk("res_cycle", cyc, ecyc);
        chk("res_value", res_value, eq);
        chk("res_rd", res_rd, rd);
        chk("stall_result", stall, 0);
        chk("lat_dividend", div_dividend, a);
        chk("lat_divisor", div_divisor, b);
        chk("starts", start_cnt - s0, special ? 0 : 1);
        chk("abort_result", div_abort, tmo);
        chk("timeout", timeout, tmo_seen);
        req_valid = 1'b0;
        step();
        chk("res_valid_drop", res_valid, 0);
        chk("abort_drop", div_abort, 0);
        chk("res_value_hold", res_value, eq);
    endtask

    initial begin
        logic          s;
        logic [SZ-1:0] a;
        logic [SZ-1:0] b;
        int            a0;
        int            r0;
        int            s0;

        // Reset state
        step();
        step();
        chk("rst_start", div_start, 0);
        chk("rst_abort", div_abort, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_value", res_value, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dividend", div_dividend, 0);
        reset = 1'b1;
        step();

        // Directed cases
        run_op(1'b1, 16'hA059, 16'd83, 5'd1, 16);
        run_op(1'b0, 16'd1234, 16'd0, 5'd2, 5);
        run_op(1'b1, 16'h8000, 16'hFFFF, 5'd3, 5);
        run_op(1'b0, 16'h8000, 16'hFFFF, 5'd4, 3);
        run_op(1'b0, 16'd1000, 16'd10, 5'd5, MW - 2);
        run_op(1'b0, 16'd1000, 16'd10, 5'd6, MW - 1);
        run_op(1'b1, 16'hFFF9, 16'd2, 5'd7, 0);

        // Random operations, back-to-back
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = SZ'($urandom);
            b = SZ'($urandom);
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin
                    a = 16'h8000;
                    b = 16'hFFFF;
                end
                default: ;
            endcase
            run_op(s, a, b, 5'($urandom), $urandom_range(0, MW - 1));
        end

        // Flush in the 5th WAIT cycle, then a new request next cycle
        a0 = abort_cnt;
        r0 = rv_cnt;
        mdl_delay = 1000;
        drive(1'b0, 16'h1234, 16'd3, 5'd8);
        step();
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_abort", div_abort, 1);
        chk("flush_no_result", res_valid, 0);
        run_op(1'b0, 16'd100, 16'd7, 5'd9, 4);
        chk("flush_abort_pulses", abort_cnt - a0, 1);
        chk("flush_results", rv_cnt - r0, 1);

        // Flush in IDLE blocks acceptance
        s0 = start_cnt;
        drive(1'b0, 16'd50, 16'd5, 5'd10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_idle_start", div_start, 0);
        chk("flush_idle_stall", stall, 1);
        chk("flush_idle_starts", start_cnt - s0, 0);
        run_op(1'b0, 16'd50, 16'd5, 5'd10, 2);

        // Hang: divider never answers; timeout is sticky
        run_op(1'b1, 16'h7777, 16'd5, 5'd11, 1000);
        run_op(1'b0, 16'd90, 16'd9, 5'd12, 1);

        // Reset mid-WAIT
        mdl_delay = 1000;
        drive(1'b1, 16'h4321, 16'd7, 5'd13);
        step();
        repeat (4) step();
        #2;
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mid_rst_start", div_start, 0);
        chk("mid_rst_abort", div_abort, 0);
        chk("mid_rst_signed", div_signed, 0);
        chk("mid_rst_dividend", div_dividend, 0);
        chk("mid_rst_divisor", div_divisor, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_value", res_value, 0);
        chk("mid_rst_res_rd", res_rd, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_stall", stall, 0);
        tmo_seen = 0;
        step();
        reset = 1'b1;
        step();
        r0 = rv_cnt;
        chk("post_rst_no_result", res_valid, 0);
        run_op(1'b1, 16'hFF00, 16'd16, 5'd14, 6);
        chk("post_rst_results", rv_cnt - r0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
